mem_read_responder: RTL and testbench

//  Read-side memory model driving the a_bus/b_bus operand ports of the matrix top.

---
 rtl/mem_read_responder.sv | 104 ++++++++++
 tb/tb_mem_read_responder.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/mem_read_responder.sv
// Read-side memory model: one request at a time on req/ack, returns an address-derived pattern.
// Define MEM_RESP_RAND_LAT_EN to add 0..7 cycles of LFSR-driven jitter to the fixed LATENCY.
module mem_read_responder #(
    parameter int unsigned ADDR_W  = 16,
    parameter int unsigned DATA_W  = 8,
    parameter int unsigned LANES   = 16,
    parameter int unsigned LATENCY = 2,
    parameter int unsigned CNT_W   = 16
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      req,
    input  logic [ADDR_W-1:0]         addr,
    output logic                      ack,
    output logic [DATA_W*LANES-1:0]   rdata,
    output logic                      busy,
    output logic [CNT_W-1:0]          req_cnt,
    output logic                      proto_err
);

    localparam int unsigned PROD_W = ADDR_W + $clog2(LANES);
    // Wide enough for LATENCY-1 plus the optional 3-bit jitter.
    localparam int unsigned LAT_W  = 9;

    typedef enum logic [1:0] {StIdle, StWait, StAck} state_e;

    state_e                    state;
    logic [ADDR_W-1:0]         addr_q;
    logic [LAT_W-1:0]          lat_cnt;
    logic [LAT_W-1:0]          lat_load;
    logic [PROD_W-1:0]         base;
    logic [DATA_W*LANES-1:0]   pattern;

`ifdef MEM_RESP_RAND_LAT_EN
    logic [15:0] lfsr;
    assign lat_load = LAT_W'(LATENCY - 1) + LAT_W'(lfsr[2:0]);
`else
    assign lat_load = LAT_W'(LATENCY - 1);
`endif

    always_comb begin
        pattern = '0;
        base    = PROD_W'(addr_q) * PROD_W'(LANES);
        for (int i = 0; i < LANES; i++) begin
            pattern[i*DATA_W +: DATA_W] = DATA_W'(base + PROD_W'(i));
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= StIdle;
            addr_q    <= '0;
            lat_cnt   <= '0;
            ack       <= 1'b0;
            rdata     <= '0;
            busy      <= 1'b0;
            req_cnt   <= '0;
            proto_err <= 1'b0;
`ifdef MEM_RESP_RAND_LAT_EN
            lfsr      <= 16'hACE1;
`endif
        end else begin
            ack <= 1'b0;
            case (state)
                StIdle: begin
                    if (req) begin
                        addr_q  <= addr;
                        lat_cnt <= lat_load;
                        busy    <= 1'b1;
                        state   <= StWait;
`ifdef MEM_RESP_RAND_LAT_EN
                        // Fibonacci taps 16,14,13,11
                        lfsr    <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
`endif
                    end
                end
                StWait: begin
                    // A dropped request abandons the transfer; it never gets an ack.
                    if (!req) begin
                        proto_err <= 1'b1;
                        busy      <= 1'b0;
                        state     <= StIdle;
                    end else if (lat_cnt == '0) begin
                        ack     <= 1'b1;
                        rdata   <= pattern;
                        req_cnt <= req_cnt + CNT_W'(1);
                        state   <= StAck;
                    end else begin
                        lat_cnt <= lat_cnt - LAT_W'(1);
                    end
                end
                StAck: begin
                    busy  <= 1'b0;
                    state <= StIdle;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_read_responder.sv
// Directed and randomized bench for mem_read_responder against a transaction-level model.
module tb_mem_read_responder;

    localparam int unsigned L     = 2;
    localparam int unsigned LANES = 16;
    localparam int unsigned DW    = 8;
    localparam int unsigned CW    = 4;

    logic                  clk = 1'b0;
    logic                  reset;
    logic                  req;
    logic [15:0]           addr;
    logic                  ack;
    logic [DW*LANES-1:0]   rdata;
    logic                  busy;
    logic [CW-1:0]         req_cnt;
    logic                  proto_err;

    int n_checks = 0;
    int n_fails  = 0;
    int model_cnt = 0;
    bit model_perr = 1'b0;
`ifdef MEM_RESP_RAND_LAT_EN
    logic [15:0] model_lfsr = 16'hACE1;
`endif

    mem_read_responder #(
        .ADDR_W (16),
        .DATA_W (DW),
        .LANES  (LANES),
        .LATENCY(L),
        .CNT_W  (CW)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .req      (req),
        .addr     (addr),
        .ack      (ack),
        .rdata    (rdata),
        .busy     (busy),
        .req_cnt  (req_cnt),
        .proto_err(proto_err)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        assert (got === exp) else begin
            n_fails++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [127:0] pattern(input logic [15:0] a);
        logic [127:0] r;
        r = '0;
        for (int i = 0; i < 16; i++) r[i*8 +: 8] = 8'(32'(a) * 16 + i);
        return r;
    endfunction

    // Cycles from accept edge to the edge that raises ack.
    task automatic model_accept(output int lat);
        lat = L;
`ifdef MEM_RESP_RAND_LAT_EN
        lat = L + int'(model_lfsr[2:0]);
        model_lfsr = {model_lfsr[14:0], ^(model_lfsr & 16'hB400)};
`endif
    endtask

    task automatic do_reset();
        reset = 1'b1;
        req   = 1'b1;
        addr  = 16'($urandom);
        repeat (3) begin
            @(negedge clk);
            check("reset_ack", 128'(ack), 128'(0));
            check("reset_busy", 128'(busy), 128'(0));
            check("reset_req_cnt", 128'(req_cnt), 128'(0));
            check("reset_rdata", 128'(rdata), 128'(0));
            check("reset_proto_err", 128'(proto_err), 128'(0));
        end
        reset      = 1'b0;
        req        = 1'b0;
        model_cnt  = 0;
        model_perr = 1'b0;
`ifdef MEM_RESP_RAND_LAT_EN
        model_lfsr = 16'hACE1;
`endif
    endtask

    // Called at a negedge. chained: previous beat's ack is visible now and req stays high.
    task automatic read_beat(input logic [15:0] a, input bit chained);
        int lat, target, n;
        req  = 1'b1;
        addr = a;
        model_accept(lat);
        target = lat + (chained ? 2 : 1);
        n = 0;
        do begin
            @(negedge clk);
            n++;
            if (n == (chained ? 2 : 1)) check("busy_after_accept", 128'(busy), 128'(1));
        end while (!ack && n < target + 4);
        check("ack_latency", 128'(n), 128'(target));
        model_cnt = (model_cnt + 1) % (1 << CW);
        check("rdata", rdata, pattern(a));
        check("req_cnt", 128'(req_cnt), 128'(model_cnt));
    endtask

    task automatic release_req();
        req = 1'b0;
        @(negedge clk);
        check("ack_single_pulse", 128'(ack), 128'(0));
        check("busy_after_ack", 128'(busy), 128'(0));
        check("req_cnt_after_ack", 128'(req_cnt), 128'(model_cnt));
        check("proto_err_idle", 128'(proto_err), 128'(model_perr));
    endtask

    task automatic no_ack_for(input int cycles, input string tag);
        bit seen = 1'b0;
        req = 1'b0;
        repeat (cycles) begin
            @(negedge clk);
            if (ack) seen = 1'b1;
        end
        check(tag, 128'(seen), 128'(0));
    endtask

    initial begin
        int lat;
        bit kept;
        reset = 1'b1;
        req   = 1'b0;
        addr  = '0;
        @(negedge clk);
        do_reset();
        repeat (2) @(negedge clk);

        read_beat(16'd3, 1'b0);
        release_req();

        read_beat(16'd0, 1'b0);
        read_beat(16'd1, 1'b1);
        release_req();

        // Drop req one cycle into the wait: sticky error, no ack.
        req  = 1'b1;
        addr = 16'h0055;
        model_accept(lat);
        @(negedge clk);
        check("drop_busy", 128'(busy), 128'(1));
        req = 1'b0;
        @(negedge clk);
        model_perr = 1'b1;
        check("drop_proto_err", 128'(proto_err), 128'(1));
        check("drop_busy_clear", 128'(busy), 128'(0));
        no_ack_for(lat + 3, "drop_no_ack");
        read_beat(16'd7, 1'b0);
        release_req();

        read_beat(16'hFFFF, 1'b0);
        check("wrap_lane0", 128'(rdata[7:0]), 128'(8'hF0));
        check("wrap_lane15", 128'(rdata[127:120]), 128'(8'hFF));
        release_req();

        // Reset in the middle of a transfer drops it.
        req  = 1'b1;
        addr = 16'd9;
        model_accept(lat);
        @(negedge clk);
        check("mid_busy", 128'(busy), 128'(1));
        do_reset();
        no_ack_for(lat + 3, "reset_drops_ack");

        kept = 1'b0;
        for (int k = 0; k < 40; k++) begin
            read_beat(16'($urandom), kept);
            if ($urandom_range(0, 2) == 0) begin
                kept = 1'b1;
            end else begin
                kept = 1'b0;
                release_req();
                repeat ($urandom_range(0, 3)) @(negedge clk);
            end
        end
        if (kept) release_req();

        // After reset the latency sequence must restart from the seed.
        do_reset();
        for (int k = 0; k < 10; k++) begin
            read_beat(16'($urandom), 1'b0);
            release_req();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
